// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped direction counters + tagged BTB for fetch prediction.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor #(
   parameter int PC_W      = 9,
   parameter int IDX_W     = 6,
   parameter int CNT_W     = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [PC_W-1:0] fetch_pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   output logic            pred_hit,
   output logic            ready,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_is_jump,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_mispred,
   input  logic            upd_is_call,
   input  logic            upd_is_ret,
   output logic [31:0]     br_count,
   output logic [31:0]     miss_count
);
   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = PC_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  init_idx_q, init_idx_d;
   logic [31:0]       br_count_q, br_count_d;
   logic [31:0]       miss_count_q, miss_count_d;

   logic              valid_q [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [PC_W-1:0]   tgt_q   [ENTRIES];
   logic [CNT_W-1:0]  ctr_q   [ENTRIES];

   logic [IDX_W-1:0]  f_idx, u_idx, wr_idx;
   logic [TAG_W-1:0]  f_tag, u_tag;
   logic              upd_act, u_hit;
   logic              wr_en, wr_btb, wr_valid;
   logic [CNT_W-1:0]  wr_ctr, ctr_base, ctr_cur;
   logic              ras_use;
   logic [PC_W-1:0]   ras_tgt;
   logic              unused_bits;

   assign f_idx   = fetch_pc[IDX_W+1:2];
   assign f_tag   = fetch_pc[PC_W-1:IDX_W+2];
   assign u_idx   = upd_pc[IDX_W+1:2];
   assign u_tag   = upd_pc[PC_W-1:IDX_W+2];
   assign upd_act = (state_q == ST_READY) && upd_valid;
   assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign ctr_cur = ctr_q[u_idx];
   // An aliasing write starts training from the weakly-not-taken value.
   assign ctr_base = u_hit ? ctr_cur : CNT_INIT;

   assign ready      = (state_q == ST_READY);
   assign br_count   = br_count_q;
   assign miss_count = miss_count_q;

   always_comb begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = '0;
      if (state_q == ST_READY && valid_q[f_idx] && tag_q[f_idx] == f_tag) begin
         pred_hit    = 1'b1;
         pred_taken  = ctr_q[f_idx][CNT_W-1];
         pred_target = ras_use ? ras_tgt : tgt_q[f_idx];
      end
   end

   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      br_count_d   = br_count_q;
      miss_count_d = miss_count_q;
      wr_en        = 1'b0;
      wr_btb       = 1'b0;
      wr_idx       = u_idx;
      wr_valid     = 1'b1;
      wr_ctr       = ctr_cur;
      if (state_q == ST_INIT) begin
         wr_en      = 1'b1;
         wr_btb     = 1'b1;
         wr_idx     = init_idx_q;
         wr_valid   = 1'b0;
         wr_ctr     = CNT_INIT;
         init_idx_d = init_idx_q + IDX_W'(1);
         if (init_idx_q == '1) state_d = ST_READY;
      end else if (upd_act) begin
         wr_en      = 1'b1;
         br_count_d = br_count_q + 32'd1;
         if (upd_mispred) miss_count_d = miss_count_q + 32'd1;
         if (upd_is_jump) begin
            wr_btb = 1'b1;
            wr_ctr = CNT_MAX;
         end else if (upd_taken) begin
            wr_btb = 1'b1;
            wr_ctr = (ctr_base == CNT_MAX) ? CNT_MAX : ctr_base + CNT_W'(1);
         end else begin
            wr_ctr = (ctr_cur == '0) ? '0 : ctr_cur - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_INIT;
         init_idx_q   <= '0;
         br_count_q   <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         br_count_q   <= br_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && wr_en) begin
         ctr_q[wr_idx] <= wr_ctr;
         if (wr_btb) begin
            valid_q[wr_idx] <= wr_valid;
            tag_q[wr_idx]   <= u_tag;
            tgt_q[wr_idx]   <= upd_target;
         end
      end
   end

`ifdef BP_RAS_EN
   localparam int PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RCNT_W = $clog2(RAS_DEPTH + 1);

   logic              ret_q [ENTRIES];
   logic [PC_W-1:0]   ras_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ras_top_q, ras_top_d, ras_wr_ptr;
   logic [RCNT_W-1:0] ras_cnt_q, ras_cnt_d;
   logic              ras_wr_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
   endfunction

   assign ras_use = ret_q[f_idx] && (ras_cnt_q != '0);
   assign ras_tgt = ras_q[ras_top_q];

   always_comb begin
      ras_top_d  = ras_top_q;
      ras_cnt_d  = ras_cnt_q;
      ras_wr_en  = 1'b0;
      ras_wr_ptr = ras_top_q;
      if (upd_act) begin
         if (upd_is_call && upd_is_ret && ras_cnt_q != '0) begin
            ras_wr_en = 1'b1;
         end else if (upd_is_call) begin
            // Full stack: pointer wraps onto the oldest entry and overwrites it.
            ras_top_d  = ptr_inc(ras_top_q);
            ras_wr_ptr = ptr_inc(ras_top_q);
            ras_wr_en  = 1'b1;
            if (ras_cnt_q != RCNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RCNT_W'(1);
         end else if (upd_is_ret && ras_cnt_q != '0) begin
            ras_top_d = ptr_dec(ras_top_q);
            ras_cnt_d = ras_cnt_q - RCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ras_top_q <= '0;
         ras_cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         ras_top_q <= ras_top_d;
         ras_cnt_q <= ras_cnt_d;
         if (ras_wr_en) ras_q[ras_wr_ptr] <= upd_pc + PC_W'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && wr_en && wr_btb) ret_q[wr_idx] <= upd_act && upd_is_ret;
   end
`else
   assign ras_use = 1'b0;
   assign ras_tgt = '0;
`endif

   assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_is_call, upd_is_ret};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - table-driven scoreboard bench for branch_predictor.
module tb_branch_predictor;
   localparam int PC_W = 9;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [PC_W-1:0] fetch_pc;
   logic            pred_taken, pred_hit, ready;
   logic [PC_W-1:0] pred_target;
   logic            upd_valid, upd_is_jump, upd_taken, upd_mispred, upd_is_call, upd_is_ret;
   logic [PC_W-1:0] upd_pc, upd_target;
   logic [31:0]     br_count, miss_count;

   always #5 clk = ~clk;

   branch_predictor #(.PC_W(9), .IDX_W(6), .CNT_W(2), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit), .ready(ready),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispred(upd_mispred), .upd_is_call(upd_is_call),
      .upd_is_ret(upd_is_ret), .br_count(br_count), .miss_count(miss_count)
   );

   typedef struct {
      logic uv; logic [8:0] upc; logic uj; logic ut; logic [8:0] utgt; logic um;
      logic uc; logic ur; logic [8:0] fpc; logic eh; logic et; logic [8:0] etgt;
   } vec_t;

   typedef struct { string name; logic eh; logic et; logic [8:0] etgt; } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int exp_br = 0;
   int exp_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic add(input logic uv, input logic [8:0] upc, input logic uj, input logic ut,
                      input logic [8:0] utgt, input logic um, input logic [8:0] fpc,
                      input logic eh, input logic et, input logic [8:0] etgt,
                      input logic uc = 1'b0, input logic ur = 1'b0);
      vec_t v;
      v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut; v.utgt = utgt; v.um = um;
      v.uc = uc; v.ur = ur; v.fpc = fpc; v.eh = eh; v.et = et; v.etgt = etgt;
      vecs.push_back(v);
   endtask

   task automatic idle();
      upd_valid = 0; upd_pc = '0; upd_is_jump = 0; upd_taken = 0; upd_target = '0;
      upd_mispred = 0; upd_is_call = 0; upd_is_ret = 0;
   endtask

   task automatic walk_check(input string name);
      int n = 0;
      while (!ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, n, 64);
   endtask

   initial begin
      exp_t e;
      reset_n = 0; fetch_pc = '0; idle();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", {31'd0, ready}, 0);
      chk("reset_br", br_count, 0);
      chk("reset_hit", {31'd0, pred_hit}, 0);
      reset_n = 1;

      // Init walk with random fetches and ignored updates in flight.
      for (int i = 1; i <= 64; i++) begin
         fetch_pc = 9'($urandom); upd_valid = 1; upd_is_jump = 1; upd_mispred = 1;
         upd_pc = 9'h080; upd_target = 9'h1F0;
         @(posedge clk); #1;
         if (i < 64) chk($sformatf("init_ready_%0d", i), {31'd0, ready}, 0);
         else        chk("init_ready_rise", {31'd0, ready}, 1);
         chk($sformatf("init_hit_%0d", i), {30'd0, pred_hit, pred_taken}, 0);
      end
      idle();
      chk("init_upd_ignored_br", br_count, 0);
      chk("init_upd_ignored_miss", miss_count, 0);

      //   uv  upc     uj ut utgt    um fpc     eh et etgt
      add(1, 9'h040, 0, 1, 9'h100, 1, 9'h040, 0, 0, 9'h000);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 1, 1, 9'h100);
      add(1, 9'h040, 0, 1, 9'h100, 0, 9'h040, 1, 1, 9'h100);
      add(1, 9'h040, 0, 0, 9'h000, 1, 9'h040, 1, 1, 9'h100);
      add(1, 9'h040, 0, 0, 9'h000, 1, 9'h040, 1, 1, 9'h100);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 1, 0, 9'h100);
      add(1, 9'h080, 1, 1, 9'h1F0, 1, 9'h080, 0, 0, 9'h000);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h080, 1, 1, 9'h1F0);
      add(1, 9'h044, 0, 1, 9'h0A0, 0, 9'h044, 0, 0, 9'h000);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h044, 1, 1, 9'h0A0);
      add(1, 9'h144, 0, 1, 9'h1C0, 1, 9'h144, 0, 0, 9'h000);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h044, 0, 0, 9'h000);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h144, 1, 1, 9'h1C0);
      add(1, 9'h044, 0, 0, 9'h000, 0, 9'h144, 1, 1, 9'h1C0);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h144, 1, 0, 9'h1C0);
      // Lower saturation on 0x40 (ctr 01 -> 00 -> 00 -> 01 -> 10).
      add(1, 9'h040, 0, 0, 9'h000, 0, 9'h040, 1, 0, 9'h100);
      add(1, 9'h040, 0, 0, 9'h000, 0, 9'h040, 1, 0, 9'h100);
      add(1, 9'h040, 0, 1, 9'h100, 0, 9'h040, 1, 0, 9'h100);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 1, 0, 9'h100);
      add(1, 9'h040, 0, 1, 9'h100, 0, 9'h040, 1, 0, 9'h100);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 1, 1, 9'h100);
      // Upper saturation on 0x80 (ctr 11 -> 11 -> 10).
      add(1, 9'h080, 0, 1, 9'h1F0, 0, 9'h080, 1, 1, 9'h1F0);
      add(1, 9'h080, 0, 0, 9'h000, 1, 9'h080, 1, 1, 9'h1F0);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h080, 1, 1, 9'h1F0);
`ifdef BP_RAS_EN
      add(1, 9'h010, 1, 1, 9'h030, 0, 9'h000, 0, 0, 9'h000, 1'b1, 1'b0);
      add(1, 9'h010, 1, 1, 9'h030, 0, 9'h010, 1, 1, 9'h030, 1'b1, 1'b0);
      add(1, 9'h060, 1, 1, 9'h000, 1, 9'h010, 1, 1, 9'h030, 1'b0, 1'b1);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h060, 1, 1, 9'h014);
      add(1, 9'h060, 1, 1, 9'h000, 0, 9'h010, 1, 1, 9'h030, 1'b0, 1'b1);
      add(0, 9'h000, 0, 0, 9'h000, 0, 9'h060, 1, 1, 9'h000);
`endif

      foreach (vecs[i]) begin
         @(negedge clk);
         upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_is_jump = vecs[i].uj;
         upd_taken = vecs[i].ut; upd_target = vecs[i].utgt; upd_mispred = vecs[i].um;
         upd_is_call = vecs[i].uc; upd_is_ret = vecs[i].ur; fetch_pc = vecs[i].fpc;
         sb.push_back('{$sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].etgt});
         if (vecs[i].uv) begin
            exp_br++;
            if (vecs[i].um) exp_miss++;
         end
         #2;
         e = sb.pop_front();
         chk({e.name, "_hit"}, {31'd0, pred_hit}, {31'd0, e.eh});
         chk({e.name, "_taken"}, {31'd0, pred_taken}, {31'd0, e.et});
         chk({e.name, "_target"}, {23'd0, pred_target}, {23'd0, e.etgt});
      end
      @(negedge clk);
      idle();
      chk("table_br_count", br_count, exp_br);
      chk("table_miss_count", miss_count, exp_miss);

      // One-cycle reset mid-run clears counters and restarts the walk.
      reset_n = 0;
      @(negedge clk);
      chk("rst_br", br_count, 0);
      chk("rst_miss", miss_count, 0);
      chk("rst_ready", {31'd0, ready}, 0);
      reset_n = 1;
      walk_check("rst_walk_len");
      fetch_pc = 9'h080;
      #1;
      chk("rst_cleared_hit", {31'd0, pred_hit}, 0);

      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         upd_valid = 1; upd_pc = 9'(9'h100 + 4 * k); upd_is_jump = 0; upd_taken = 1;
         upd_target = 9'h020; upd_mispred = (k == 1 || k == 3);
      end
      @(negedge clk);
      idle();
      chk("cnt5_br", br_count, 5);
      chk("cnt5_miss", miss_count, 2);

      // Reset asserted partway through the walk restarts it from index 0.
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("midwalk_ready", {31'd0, ready}, 0);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      walk_check("midwalk_walk_len");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
